// File: rtl/disp_sched_pkg.sv
// Shared types and helpers for the display source scheduler.
package disp_sched_pkg;

  typedef enum logic {IDLE = 1'b0, SHOW = 1'b1} state_e;

  localparam int NUM_W   = 14;
  localparam int MAX_REQ = 32;

  // Clamp a display value to the largest value the 4 digits may show.
  function automatic logic [NUM_W-1:0] sat(input logic [NUM_W-1:0] v,
                                           input logic [NUM_W-1:0] max_val);
    return (v > max_val) ? max_val : v;
  endfunction

  // Isolate the lowest set bit: index 0 is the highest-priority requester.
  function automatic logic [MAX_REQ-1:0] prio_onehot(input logic [MAX_REQ-1:0] r);
    return r & (~r + 1'b1);
  endfunction

endpackage

// File: rtl/disp_hold_timer.sv
// Loadable down-counter with a zero flag; a load takes precedence over a decrement.
module disp_hold_timer #(
  parameter int W = 8
) (
  input  logic         clk_500Hz,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/disp_source_sched.sv
// Fixed-priority owner selection for the shared 7-segment display with a minimum hold time.
// Optional per-source blinking is compiled in when DISP_BLINK_EN is defined.
module disp_source_sched
  import disp_sched_pkg::*;
#(
  parameter int N_REQ      = 3,
  parameter int MIN_HOLD   = 250,
  parameter int BLINK_HALF = 125,
  parameter int MAX_VAL    = 9999
) (
  input  logic                   clk_500Hz,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [NUM_W*N_REQ-1:0] num,
`ifdef DISP_BLINK_EN
  input  logic [N_REQ-1:0]       blink_req,
`endif
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       released,
  output logic [NUM_W-1:0]       disp_number,
  output logic                   disp_blank
);

  localparam int HOLD_LD = (MIN_HOLD < 1) ? 1 : MIN_HOLD;
  localparam int HOLD_W  = $clog2(HOLD_LD + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_LD - 1);
  localparam logic [NUM_W-1:0]  MAXV = NUM_W'(MAX_VAL);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   released_q, released_d;
  logic [NUM_W-1:0]   number_q, number_d;
  logic               blank_q, blank_d;

  logic [MAX_REQ-1:0] win_oh_full;
  logic               unused_win_hi;
  logic [N_REQ-1:0]   win_oh;
  logic [NUM_W-1:0]   win_num, own_num;
  logic               any_req, own_req, hi_req;
  logic               hold_load, hold_dec, hold_zero;

  assign win_oh_full   = prio_onehot(MAX_REQ'(req));
  assign win_oh        = win_oh_full[N_REQ-1:0];
  assign unused_win_hi = |win_oh_full[MAX_REQ-1:N_REQ];

  assign any_req = |req;
  assign own_req = |(req & grant_q);
  // Bits below the owner's index are the higher-priority sources.
  assign hi_req  = |(req & (grant_q - 1'b1));

  always_comb begin
    win_num = '0;
    own_num = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_oh[i])  win_num = num[NUM_W*i +: NUM_W];
      if (grant_q[i]) own_num = num[NUM_W*i +: NUM_W];
    end
  end

  disp_hold_timer #(.W(HOLD_W)) u_hold (
    .clk_500Hz  (clk_500Hz),
    .rst        (rst),
    .load_i     (hold_load),
    .load_val_i (HOLD_RELOAD),
    .dec_i      (hold_dec),
    .zero_o     (hold_zero)
  );

`ifdef DISP_BLINK_EN
  localparam int BL_LD = (BLINK_HALF < 1) ? 1 : BLINK_HALF;
  localparam int BL_W  = $clog2(BL_LD + 1);
  localparam logic [BL_W-1:0] BL_RELOAD = BL_W'(BL_LD - 1);

  logic phase_q, phase_d;
  logic grant_chg, blink_load, blink_dec, blink_zero;

  disp_hold_timer #(.W(BL_W)) u_blink (
    .clk_500Hz  (clk_500Hz),
    .rst        (rst),
    .load_i     (blink_load),
    .load_val_i (BL_RELOAD),
    .dec_i      (blink_dec),
    .zero_o     (blink_zero)
  );
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    released_d = '0;
    number_d   = number_q;
    blank_d    = blank_q;
    hold_load  = 1'b0;
    hold_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d  = '0;
        number_d = '0;
        blank_d  = 1'b1;
        if (any_req) begin
          state_d   = SHOW;
          grant_d   = win_oh;
          number_d  = sat(win_num, MAXV);
          blank_d   = 1'b0;
          hold_load = 1'b1;
        end
      end
      SHOW: begin
        blank_d = 1'b0;
        if (own_req) number_d = sat(own_num, MAXV);
        if (!hold_zero) begin
          hold_dec = 1'b1;
        end else if (hi_req || !own_req) begin
          // Hand over without an idle gap when anyone else is waiting.
          released_d = grant_q;
          if (any_req) begin
            grant_d   = win_oh;
            number_d  = sat(win_num, MAXV);
            hold_load = 1'b1;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            number_d = '0;
            blank_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef DISP_BLINK_EN
    grant_chg  = (grant_d != grant_q);
    blink_load = grant_chg || ((state_q == SHOW) && blink_zero);
    blink_dec  = (state_q == SHOW);
    phase_d    = phase_q;
    if (grant_chg) begin
      phase_d = 1'b0;
    end else if ((state_q == SHOW) && blink_zero) begin
      phase_d = ~phase_q;
    end
    if (state_d == SHOW) blank_d = (|(blink_req & grant_d)) & phase_d;
`endif
  end

  always_ff @(posedge clk_500Hz or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      released_q <= '0;
      number_q   <= '0;
      blank_q    <= 1'b1;
`ifdef DISP_BLINK_EN
      phase_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      released_q <= released_d;
      number_q   <= number_d;
      blank_q    <= blank_d;
`ifdef DISP_BLINK_EN
      phase_q    <= phase_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign released    = released_q;
  assign disp_number = number_q;
  assign disp_blank  = blank_q;

endmodule

// File: tb/tb_disp_source_sched.sv
// Self-checking bench for disp_source_sched: vector table, corner sequences, random vs model.
module tb_disp_source_sched;

  localparam int N    = 3;
  localparam int HOLD = 4;
  localparam int BH   = 2;

  logic        clk_500Hz = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [41:0] num;
`ifdef DISP_BLINK_EN
  logic [2:0]  blink_req;
`endif
  logic [2:0]  grant, released;
  logic [13:0] disp_number;
  logic        disp_blank;

  int total = 0;
  int bad   = 0;

  always #5 clk_500Hz = ~clk_500Hz;

  disp_source_sched #(
    .N_REQ(N), .MIN_HOLD(HOLD), .BLINK_HALF(BH), .MAX_VAL(9999)
  ) dut (
    .clk_500Hz   (clk_500Hz),
    .rst         (rst),
    .req         (req),
    .num         (num),
`ifdef DISP_BLINK_EN
    .blink_req   (blink_req),
`endif
    .grant       (grant),
    .released    (released),
    .disp_number (disp_number),
    .disp_blank  (disp_blank)
  );

  typedef struct {
    logic [2:0]  req;
    logic [13:0] n0, n1, n2;
    logic [2:0]  eg, er;
    logic [13:0] en;
    logic        eb;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [2:0] r, input logic [13:0] n0, n1, n2,
                     input logic [2:0] eg, er, input logic [13:0] en, input logic eb);
    vec_t v;
    v.req = r; v.n0 = n0; v.n1 = n1; v.n2 = n2;
    v.eg = eg; v.er = er; v.en = en; v.eb = eb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] eg, er,
                         input logic [13:0] en, input logic eb);
    chk({nm, " grant"}, 32'(grant), 32'(eg));
    chk({nm, " released"}, 32'(released), 32'(er));
    chk({nm, " number"}, 32'(disp_number), 32'(en));
    chk({nm, " blank"}, 32'(disp_blank), 32'(eb));
  endtask

  task automatic apply(input logic [2:0] r, input logic [13:0] n0, n1, n2);
    req = r;
    num = {n2, n1, n0};
  endtask

  task automatic tick();
    @(posedge clk_500Hz);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(3'b000, 14'd0, 14'd0, 14'd0);
    tick();
    rst = 1'b0;
  endtask

  // Reference model: owner index, edges since the last grant change, last shown value.
  int          m_owner;
  int          m_age;
  logic [13:0] m_num;
  logic [2:0]  m_grant, m_rel;
  logic        m_blank;

  function automatic logic [13:0] clampv(input logic [13:0] v);
    return (v > 14'd9999) ? 14'd9999 : v;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_age = 0; m_num = '0; m_grant = '0; m_rel = '0; m_blank = 1'b1;
  endtask

  task automatic model_edge();
    int win;
    win = -1;
    for (int i = N - 1; i >= 0; i--) if (req[i]) win = i;
    m_rel = '0;
    if (m_owner < 0) begin
      if (win >= 0) begin
        m_owner = win; m_age = 0; m_num = clampv(num[14*win +: 14]);
      end else begin
        m_num = '0;
      end
    end else if (m_age < HOLD - 1) begin
      m_age++;
      if (req[m_owner]) m_num = clampv(num[14*m_owner +: 14]);
    end else if (win >= 0 && (win < m_owner || !req[m_owner])) begin
      m_rel[m_owner] = 1'b1;
      m_owner = win; m_age = 0; m_num = clampv(num[14*win +: 14]);
    end else if (req[m_owner]) begin
      m_age++;
      m_num = clampv(num[14*m_owner +: 14]);
    end else begin
      m_rel[m_owner] = 1'b1;
      m_owner = -1; m_num = '0;
    end
    m_grant = (m_owner < 0) ? 3'b000 : 3'(1 << m_owner);
`ifdef DISP_BLINK_EN
    m_blank = (m_owner < 0) ? 1'b1 : (blink_req[m_owner] && (((m_age / BH) % 2) == 1));
`else
    m_blank = (m_owner < 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    apply(3'b000, 14'd0, 14'd0, 14'd0);
`ifdef DISP_BLINK_EN
    blink_req = 3'b000;
`endif
    #2;
    chk_all("reset", 3'b000, 3'b000, 14'd0, 1'b1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) chk_all($sformatf("idle%0d", i), 3'b000, 3'b000, 14'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("idle_run%0d", i), 3'b000, 3'b000, 14'd0, 1'b1);
    end

    // Single request, then release to idle.
    for (int i = 0; i < 10; i++) add(3'b100, 0, 0, 1234, 3'b100, 3'b000, 1234, 1'b0);
    add(3'b000, 0, 0, 1234, 3'b000, 3'b100, 0, 1'b1);
    add(3'b000, 0, 0, 1234, 3'b000, 3'b000, 0, 1'b1);
    // Preemption once the hold expires; then frozen value while owner is low.
    add(3'b100, 0, 0, 500, 3'b100, 3'b000, 500, 1'b0);
    for (int i = 0; i < 3; i++) add(3'b101, 42, 0, 500, 3'b100, 3'b000, 500, 1'b0);
    add(3'b101, 42, 0, 500, 3'b001, 3'b100, 42, 1'b0);
    add(3'b101, 42, 0, 500, 3'b001, 3'b000, 42, 1'b0);
    add(3'b000, 55, 0, 500, 3'b001, 3'b000, 42, 1'b0);
    add(3'b000, 55, 0, 500, 3'b001, 3'b000, 42, 1'b0);
    add(3'b000, 55, 0, 500, 3'b000, 3'b001, 0, 1'b1);
    // Early drop: one-cycle request still holds the display for the minimum time.
    add(3'b010, 0, 77, 0, 3'b010, 3'b000, 77, 1'b0);
    for (int i = 0; i < 3; i++) add(3'b000, 0, 99, 0, 3'b010, 3'b000, 77, 1'b0);
    add(3'b000, 0, 99, 0, 3'b000, 3'b010, 0, 1'b1);
    // Owner drops exactly when a higher source rises at expiry.
    add(3'b100, 0, 0, 7, 3'b100, 3'b000, 7, 1'b0);
    for (int i = 0; i < 3; i++) add(3'b100, 0, 0, 8, 3'b100, 3'b000, 8, 1'b0);
    add(3'b001, 9, 0, 8, 3'b001, 3'b100, 9, 1'b0);
    // Saturation, then owner drops with only lower sources pending.
    for (int i = 0; i < 3; i++) add(3'b001, 14000, 0, 0, 3'b001, 3'b000, 9999, 1'b0);
    add(3'b110, 14000, 3, 5, 3'b010, 3'b001, 3, 1'b0);
    for (int i = 0; i < 3; i++) add(3'b000, 0, 3, 5, 3'b010, 3'b000, 3, 1'b0);
    add(3'b000, 0, 3, 5, 3'b000, 3'b010, 0, 1'b1);

    foreach (vecs[i]) begin
      apply(vecs[i].req, vecs[i].n0, vecs[i].n1, vecs[i].n2);
      tick();
      chk_all($sformatf("tbl%0d", i), vecs[i].eg, vecs[i].er, vecs[i].en, vecs[i].eb);
    end

    // Reset in the middle of a grant returns everything at once, without a release pulse.
    apply(3'b001, 14000, 0, 0);
    tick();
    chk_all("sat", 3'b001, 3'b000, 14'd9999, 1'b0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_mid", 3'b000, 3'b000, 14'd0, 1'b1);
    tick();
    chk_all("rst_hold", 3'b000, 3'b000, 14'd0, 1'b1);
    rst = 1'b0;
    apply(3'b000, 0, 0, 0);
    tick();
    chk_all("rst_after", 3'b000, 3'b000, 14'd0, 1'b1);

`ifdef DISP_BLINK_EN
    begin
      logic [5:0] pat;
      pat = 6'b001100;
      do_reset();
      blink_req = 3'b001;
      apply(3'b001, 10, 0, 0);
      for (int i = 0; i < 6; i++) begin
        tick();
        chk($sformatf("blink_on%0d", i), 32'(disp_blank), 32'(pat[5-i]));
      end
      do_reset();
      blink_req = 3'b000;
      apply(3'b001, 10, 0, 0);
      for (int i = 0; i < 6; i++) begin
        tick();
        chk($sformatf("blink_off%0d", i), 32'(disp_blank), 32'd0);
      end
    end
`endif

    // Random traffic against the reference model.
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      num = {14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)),
             14'($urandom_range(0, 16383))};
`ifdef DISP_BLINK_EN
      if ($urandom_range(0, 15) == 0) blink_req = 3'($urandom_range(0, 7));
`endif
      @(posedge clk_500Hz);
      model_edge();
      #1;
      chk_all($sformatf("rnd%0d", i), m_grant, m_rel, m_num, m_blank);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
